// File: rtl/inertial_integrator_pkg.sv
// Shared segway definitions: integrator FSM states, fusion gain constants and
// the 16-bit saturation helper also used by the PID stage.
package inertial_integrator_pkg;

    typedef enum logic {
        CAL = 1'b0,
        RUN = 1'b1
    } inert_state_t;

    // Accelerometer-to-pitch gain and the shift that rescales the product.
    localparam int FUS_GAIN  = 327;
    localparam int FUS_SHIFT = 13;

    // Overflow shows up as the two top bits of the 17-bit value disagreeing.
    function automatic logic [15:0] sat16(input logic [16:0] x);
        logic [15:0] r;
        case (x[16:15])
            2'b01:   r = 16'h7FFF;
            2'b10:   r = 16'h8000;
            default: r = x[15:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inertial_integrator_gyro_cal.sv
// Gyro offset calibration: averages 2^CAL_LOG2 accepted samples into offset.
// offset only changes when a full window completes, so recal keeps the old one.
module gyro_cal #(
    parameter int CAL_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] sample,
    output logic [15:0] offset,
    output logic        cal_last
);

    localparam int ACC_W = 16 + CAL_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_nxt;
    logic [CAL_LOG2-1:0] cnt;

    assign acc_nxt  = acc + {{CAL_LOG2{sample[15]}}, sample};
    assign cal_last = en && (cnt == {CAL_LOG2{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            offset <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (en) begin
            if (cal_last) begin
                // Arithmetic shift by CAL_LOG2, low 16 bits, done as a slice.
                offset <= acc_nxt[CAL_LOG2 +: 16];
                acc    <= '0;
                cnt    <= '0;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/inertial_integrator.sv
// Pitch / pitch-rate integrator feeding PID. Define INERT_FUSION_EN to build the
// complementary accelerometer fusion; without it ptch is pure gyro integration.
module inertial_integrator
    import inertial_integrator_pkg::*;
#(
    parameter int          CAL_LOG2    = 3,
    parameter logic [15:0] AZ_OFFSET   = 16'h00A0,
    parameter int          FUSION_STEP = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic [15:0] ptch_rt_raw,
    input  logic [15:0] AZ,
    input  logic        recal,
    output logic [15:0] ptch,
    output logic [15:0] ptch_rt,
    output logic        vld_out,
    output logic        cal_done
);

    inert_state_t state_q, state_d;

    logic        sample_ok, cal_en, run_en;
    logic        cal_last;
    logic [15:0] offset;
    logic [16:0] rt_diff;
    logic [15:0] rt_comp;
    logic [26:0] ptch_int;
    logic [26:0] fusion;

    // recal beats a coincident sample, which is dropped.
    assign sample_ok = vld && !recal;
    assign cal_en    = sample_ok && (state_q == CAL);
    assign run_en    = sample_ok && (state_q == RUN);

    gyro_cal #(.CAL_LOG2(CAL_LOG2)) u_gyro_cal (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (recal),
        .en       (cal_en),
        .sample   (ptch_rt_raw),
        .offset   (offset),
        .cal_last (cal_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CAL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (recal)                         state_d = CAL;
        else if (state_q == CAL && cal_last) state_d = RUN;
    end

    always_comb begin
        cal_done = (state_q == RUN);
    end

    assign rt_diff = {ptch_rt_raw[15], ptch_rt_raw} - {offset[15], offset};
    assign rt_comp = sat16(rt_diff);
    assign ptch    = ptch_int[26:11];

`ifdef INERT_FUSION_EN
    localparam logic signed [25:0] GAIN_S = 26'(FUS_GAIN);

    logic signed [15:0] az_comp;
    logic signed [25:0] prod;
    logic signed [15:0] ptch_acc;
    logic               unused_prod_lo;

    assign az_comp  = AZ - AZ_OFFSET;
    assign prod     = az_comp * GAIN_S;
    assign ptch_acc = {{3{prod[25]}}, prod[25:FUS_SHIFT]};
    assign unused_prod_lo = ^prod[FUS_SHIFT-1:0];

    // Pull the integrator one step toward the accelerometer pitch.
    assign fusion = (ptch_acc > $signed(ptch)) ? 27'(FUSION_STEP)
                                               : -27'(FUSION_STEP);
`else
    logic unused_fusion_cfg;

    assign unused_fusion_cfg = ^{AZ, AZ_OFFSET, 32'(FUSION_STEP)};
    assign fusion            = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptch_int <= '0;
            ptch_rt  <= '0;
            vld_out  <= 1'b0;
        end else begin
            vld_out <= run_en;
            if (recal || (cal_en && cal_last)) begin
                ptch_int <= '0;
            end else if (run_en) begin
                ptch_int <= ptch_int - {{11{rt_comp[15]}}, rt_comp} + fusion;
                ptch_rt  <= rt_comp;
            end
        end
    end

endmodule

// File: tb/tb_inertial_integrator.sv
// Scoreboard bench for inertial_integrator: a behavioural model queues expected
// ptch/ptch_rt per RUN sample and a monitor pops them on each vld_out.
module tb_inertial_integrator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic        recal = 1'b0;
    logic [15:0] ptch_rt_raw = '0;
    logic [15:0] AZ = '0;
    logic [15:0] ptch, ptch_rt;
    logic        vld_out, cal_done;

    inertial_integrator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vld         (vld),
        .ptch_rt_raw (ptch_rt_raw),
        .AZ          (AZ),
        .recal       (recal),
        .ptch        (ptch),
        .ptch_rt     (ptch_rt),
        .vld_out     (vld_out),
        .cal_done    (cal_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] r;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    bit               m_run = 0;
    int               m_acc = 0;
    int               m_cnt = 0;
    logic [15:0]      m_off = '0;
    logic signed [26:0] m_pint = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model(input logic [15:0] raw, input logic [15:0] az, input bit rc);
        int d;
        int fus;
        int pa;
        int cur;
        logic [15:0] azc;
        d   = 0;
        fus = 0;
        pa  = 0;
        cur = 0;
        azc = az;
        if (rc) begin
            m_acc = 0; m_cnt = 0; m_pint = '0; m_run = 0;
        end else if (!m_run) begin
            m_acc += int'($signed(raw));
            m_cnt++;
            if (m_cnt == 8) begin
                m_off = 16'(m_acc >>> 3);
                m_pint = '0; m_run = 1; m_acc = 0; m_cnt = 0;
            end
        end else begin
            d = int'($signed(raw)) - int'($signed(m_off));
            if (d > 32767)  d = 32767;
            if (d < -32768) d = -32768;
`ifdef INERT_FUSION_EN
            azc = az - 16'h00A0;
            pa  = (int'($signed(azc)) * 327) >>> 13;
            cur = int'($signed(m_pint[26:11]));
            fus = (pa > cur) ? 1024 : -1024;
`endif
            m_pint = m_pint - 27'(d) + 27'(fus);
            q.push_back({m_pint[26:11], 16'(d)});
        end
    endtask

    task automatic send(input logic [15:0] raw, input logic [15:0] az, input bit rc);
        @(negedge clk);
        vld = 1'b1; recal = rc; ptch_rt_raw = raw; AZ = az;
        model(raw, az, rc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vld = 1'b0; recal = 1'b0;
        end
    endtask

    exp_t e;
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("cal_done", 32'(cal_done), 32'(m_run));
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("vld_out", 32'(vld_out), 32'd1);
                chk("ptch", 32'(ptch), 32'(e.p));
                chk("ptch_rt", 32'(ptch_rt), 32'(e.r));
            end else begin
                chk("vld_out_idle", 32'(vld_out), 32'd0);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ptch", 32'(ptch), 0);
        chk("rst_ptch_rt", 32'(ptch_rt), 0);
        chk("rst_vld_out", 32'(vld_out), 0);
        chk("rst_cal_done", 32'(cal_done), 0);
        rst_n = 1'b1;

        repeat (8) send(16'h0050, 16'h00A0, 0);
        idle(1);
        chk("cal_done_up", 32'(cal_done), 1);
        send(16'h0050, 16'h00A0, 0);
        idle(1);
        chk("offset_comp", 32'(ptch_rt), 0);

`ifdef INERT_FUSION_EN
        repeat (4) send(16'h0050, 16'h00A0, 0);
        idle(1);
`endif
        repeat (8) send(16'hFF50, 16'h00A0, 0);
        idle(1);
`ifndef INERT_FUSION_EN
        chk("gyro_ptch", 32'(ptch), 32'h0001);
        chk("gyro_rt", 32'(ptch_rt), 32'hFF00);
`endif

        send(16'h8000, 16'h00A0, 0);
        idle(1);
        chk("sat_neg", 32'(ptch_rt), 32'h8000);

        send(16'h1234, 16'h00A0, 1);
        idle(1);
        chk("recal_cd", 32'(cal_done), 0);
        repeat (7) send(16'hFFB0, 16'h00A0, 0);
        idle(1);
        chk("cal7_cd", 32'(cal_done), 0);
        send(16'hFFB0, 16'h00A0, 0);
        idle(1);
        chk("cal8_cd", 32'(cal_done), 1);
        send(16'h7FFF, 16'h00A0, 0);
        idle(1);
        chk("sat_pos", 32'(ptch_rt), 32'h7FFF);

        repeat (40) begin
            send(16'($urandom), 16'($urandom), $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);

        send(16'h0000, 16'h00A0, 1);
        repeat (8) send(16'hFFB0, 16'h00A0, 0);
        repeat (3) send(16'h8000, 16'h00A0, 0);
        idle(1);
        chk("ptch_nz", 32'(ptch != 16'h0000), 1);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ptch", 32'(ptch), 0);
        chk("mid_rst_ptch_rt", 32'(ptch_rt), 0);
        chk("mid_rst_vld_out", 32'(vld_out), 0);
        chk("mid_rst_cal_done", 32'(cal_done), 0);
        m_run = 0; m_acc = 0; m_cnt = 0; m_off = '0; m_pint = '0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) send(16'h0050, 16'h00A0, 0);
        idle(1);
        chk("post_rst_cal", 32'(cal_done), 1);
        send(16'h0050, 16'h00A0, 0);
        idle(2);
        chk("post_rst_rt", 32'(ptch_rt), 0);
        chk("q_empty", 32'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
